// File: rtl/pulse_event_sync_if.sv
// Event-crossing bundle: source-domain toggle in, destination-domain pulse out.
// PULSE_EVENT_SYNC_CNT_EN adds the delivered-event counter and its CNT_W width.
interface pulse_event_sync_if
`ifdef PULSE_EVENT_SYNC_CNT_EN
  #(parameter int CNT_W = 8)
`endif
  ();
  logic i_toggle_aclk;
  logic o_pulse_bclk;
`ifdef PULSE_EVENT_SYNC_CNT_EN
  logic [CNT_W-1:0] o_event_cnt;
`endif

  modport master (
    output i_toggle_aclk,
`ifdef PULSE_EVENT_SYNC_CNT_EN
    input  o_event_cnt,
`endif
    input  o_pulse_bclk
  );

  modport slave (
    input  i_toggle_aclk,
`ifdef PULSE_EVENT_SYNC_CNT_EN
    output o_event_cnt,
`endif
    output o_pulse_bclk
  );
endinterface

// File: rtl/pulse_event_sync.sv
// Receiving half of a toggle-encoded pulse crossing: synchronize, edge-detect, one pulse per event.
// Optional delivered-event counter enabled by defining PULSE_EVENT_SYNC_CNT_EN.
module pulse_event_sync #(
  parameter int SYNC_STAGES = 2
`ifdef PULSE_EVENT_SYNC_CNT_EN
  ,
  parameter int CNT_W = 8
`endif
) (
  input  logic               i_bclk,
  input  logic               i_rst_n,
  pulse_event_sync_if.slave  bus
);
  localparam int WARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [WARM_W-1:0] WARM_INIT = WARM_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   pulse_q, pulse_d;
  logic [WARM_W-1:0]      warm_q, warm_d;

  // Warm-up masks the chain settling onto a toggle level that was already set at reset.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], bus.i_toggle_aclk};
    prev_d  = sync_q[SYNC_STAGES-1];
    warm_d  = (warm_q == '0) ? warm_q : warm_q - WARM_W'(1);
    pulse_d = (warm_q == '0) && (sync_q[SYNC_STAGES-1] ^ prev_q);
  end

  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
      warm_q  <= WARM_INIT;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
      warm_q  <= warm_d;
    end
  end

  assign bus.o_pulse_bclk = pulse_q;

`ifdef PULSE_EVENT_SYNC_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = pulse_q ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign bus.o_event_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_pulse_event_sync.sv
// Directed bench for pulse_event_sync at SYNC_STAGES=2 and 3 with a pulse-timing scoreboard.
module tb_pulse_event_sync;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   n2 = 0, n3 = 0;
  int   q2[$], q3[$];
  int   exp_cnt = 0;
  logic last2 = 1'b0, last3 = 1'b0;

`ifdef PULSE_EVENT_SYNC_CNT_EN
  pulse_event_sync_if #(.CNT_W(8)) if2 ();
  pulse_event_sync_if #(.CNT_W(8)) if3 ();
  pulse_event_sync #(.SYNC_STAGES(2), .CNT_W(8)) dut2 (.i_bclk(clk), .i_rst_n(rst_n), .bus(if2));
  pulse_event_sync #(.SYNC_STAGES(3), .CNT_W(8)) dut3 (.i_bclk(clk), .i_rst_n(rst_n), .bus(if3));
`else
  pulse_event_sync_if if2 ();
  pulse_event_sync_if if3 ();
  pulse_event_sync #(.SYNC_STAGES(2)) dut2 (.i_bclk(clk), .i_rst_n(rst_n), .bus(if2));
  pulse_event_sync #(.SYNC_STAGES(3)) dut3 (.i_bclk(clk), .i_rst_n(rst_n), .bus(if3));
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard monitors: each pulse pops one expected rise edge (+1 slack allowed).
  always @(negedge clk) begin
    if (!rst_n) last2 <= 1'b0;
    else begin
      if (last2) chk("width2", int'(if2.o_pulse_bclk), 0);
      if (if2.o_pulse_bclk && !last2) begin
        n2++;
        if (q2.size() == 0) chk("spurious2", cyc, -1);
        else begin
          int e;
          e = q2.pop_front();
          chk("lat2", cyc, (cyc == e + 1) ? e + 1 : e);
        end
      end
      last2 <= if2.o_pulse_bclk;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) last3 <= 1'b0;
    else begin
      if (last3) chk("width3", int'(if3.o_pulse_bclk), 0);
      if (if3.o_pulse_bclk && !last3) begin
        n3++;
        if (q3.size() == 0) chk("spurious3", cyc, -1);
        else begin
          int e;
          e = q3.pop_front();
          chk("lat3", cyc, (cyc == e + 1) ? e + 1 : e);
        end
      end
      last3 <= if3.o_pulse_bclk;
    end
  end

  task automatic drive_tgl(input logic v);
    if2.i_toggle_aclk = v;
    if3.i_toggle_aclk = v;
  endtask

  // Flip mid-cycle; first sampling edge is k = cyc+1, pulse expected after edge k+SYNC_STAGES.
  task automatic flip(input bit expect_pulse);
    int k;
    @(negedge clk);
    #1;
    drive_tgl(~if2.i_toggle_aclk);
    k = cyc + 1;
    if (expect_pulse) begin
      q2.push_back(k + 2);
      q3.push_back(k + 3);
      exp_cnt++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_cnt(input string tag);
`ifdef PULSE_EVENT_SYNC_CNT_EN
    chk({tag, "_cnt2"}, int'(if2.o_event_cnt), exp_cnt % 256);
    chk({tag, "_cnt3"}, int'(if3.o_event_cnt), exp_cnt % 256);
`else
    chk({tag, "_n"}, n3, n2);
`endif
  endtask

  task automatic reset_cycles(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    exp_cnt = 0;
    repeat (n) begin
      @(negedge clk);
      chk("rst_pulse2", int'(if2.o_pulse_bclk), 0);
      chk("rst_pulse3", int'(if3.o_pulse_bclk), 0);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    int b2, b3;
    rst_n = 1'b0;
    drive_tgl(1'b0);

    // Reset defaults and post-release quiet period.
    reset_cycles(3);
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_pulse2", int'(if2.o_pulse_bclk), 0);
      chk("post_rst_pulse3", int'(if3.o_pulse_bclk), 0);
    end
    check_cnt("reset");
    idle(4);

    // Single event.
    flip(1'b1);
    idle(8);
    chk("single_n2", n2, 1);
    chk("single_n3", n3, 1);
    chk("single_q", q2.size() + q3.size(), 0);

    // Both edges, eight cycles apart.
    flip(1'b1);
    idle(7);
    flip(1'b1);
    idle(8);
    chk("both_n2", n2, 3);
    chk("both_n3", n3, 3);
    check_cnt("both");

    // Back-to-back at the minimum spacing for the deeper synchronizer.
    repeat (4) begin
      flip(1'b1);
      idle(3);
    end
    idle(6);
    chk("b2b_n2", n2, 7);
    chk("b2b_n3", n3, 7);
    chk("b2b_q", q2.size() + q3.size(), 0);
    check_cnt("b2b");

    // Toggle already high across reset release must not pulse.
    b2 = n2; b3 = n3;
    @(negedge clk);
    rst_n = 1'b0;
    drive_tgl(1'b1);
    reset_cycles(3);
    idle(10);
    chk("tglhigh_n2", n2, b2);
    chk("tglhigh_n3", n3, b3);
    check_cnt("tglhigh");

    // Event in flight discarded by reset.
    flip(1'b0);
    idle(1);
    reset_cycles(3);
    idle(10);
    chk("midflight_n2", n2, b2);
    chk("midflight_n3", n3, b3);
    check_cnt("midflight");

    // Asynchronous clear while the pulse is high.
    flip(1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("preclr_pulse2", int'(if2.o_pulse_bclk), 1);
    rst_n = 1'b0;
    #1;
    chk("asyncclr_pulse2", int'(if2.o_pulse_bclk), 0);
    chk("asyncclr_pulse3", int'(if3.o_pulse_bclk), 0);
    reset_cycles(2);
    idle(10);
    chk("asyncclr_n2", n2, b2);
    chk("asyncclr_n3", n3, b3);

    // 256 spaced events: counter wraps back to 0.
    repeat (256) begin
      flip(1'b1);
      idle(4);
    end
    idle(8);
    chk("wrap_n2", n2, b2 + 256);
    chk("wrap_n3", n3, b3 + 256);
    chk("wrap_q", q2.size() + q3.size(), 0);
    check_cnt("wrap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pulse_event_sync.md
Name: pulse_event_sync

Overview:
- Destination-side half of the pulse clock-domain crossing. It converts a toggle-encoded event from a foreign clock domain into a single-cycle pulse in its own clock domain.
- The source domain flips `i_toggle_aclk` once per event. This block synchronizes that toggle, detects each edge, and emits one `o_pulse_bclk` cycle per event.
- It sits at the receiving boundary of any single-event crossing, for example start, done or interrupt strobes.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops; legal range 2..4.
- CNT_W, 8, event-counter width; used only with the optional feature.

Ports:
- i_bclk  input  1  sole clock of the block (destination domain).
- i_rst_n  input  1  reset, asynchronous assert, active-low.
- i_toggle_aclk  input  1  event toggle from the foreign domain; asynchronous to i_bclk; each level change is one event.
- o_pulse_bclk  output  1  one-cycle event pulse, registered, synchronous to i_bclk.
- o_event_cnt  output  CNT_W  events delivered, wraps; present only with the optional feature.

Behaviour:
- Interface: one clock (i_bclk); reset i_rst_n is asynchronous and active-low. All flops reset asynchronously on i_rst_n low and clock on the i_bclk rising edge.
- Reset values: all synchronizer flops 0, edge-history flop 0, o_pulse_bclk 0, o_event_cnt 0, warm-up counter loaded to SYNC_STAGES+1.
- Synchronizer: SYNC_STAGES-deep shift chain sampling i_toggle_aclk. Only the first stage touches the async input. No logic between stages.
- Edge detect: history flop `prev` <= last sync stage every cycle. `o_pulse_bclk` <= (last stage XOR prev), registered.
- Latency: a toggle change stable before i_bclk edge k is first sampled at edge k. o_pulse_bclk rises after edge k+SYNC_STAGES and is high for exactly one cycle. Metastability may add one cycle; it never drops or duplicates the event.
- Pulse width: always exactly one i_bclk cycle. o_pulse_bclk is 0 again one edge after it rises, and certainly by two edges after it is first seen high.
- Source contract: each toggle level must stay stable for at least 2 i_bclk periods. Two flips inside one i_bclk period may cancel; that is a source-side violation with no recovery.
- Warm-up mask:
  - After reset release, o_pulse_bclk is forced 0 for SYNC_STAGES+1 cycles while `prev` keeps tracking the chain.
  - A toggle input already at 1 during reset therefore produces no spurious pulse.
  - A genuine toggle change arriving during warm-up is also absorbed; the source must wait SYNC_STAGES+1 i_bclk cycles after reset before signalling.
- Reset mid-operation: an event in flight is discarded. o_pulse_bclk goes 0 immediately (asynchronously) and no pulse follows reset release.
- Back-to-back events: events spaced at least SYNC_STAGES+1 i_bclk cycles apart give distinct pulses with at least one low cycle between them.
- No state machine beyond the warm-up counter (idle-masked, then run). The counter saturates at 0 and stays there until the next reset.

Optional Feature:
- Macro: PULSE_EVENT_SYNC_CNT_EN.
- Defined:
  - o_event_cnt (CNT_W bits) increments by 1 in the cycle after each o_pulse_bclk assertion.
  - Wraps modulo 2^CNT_W with no saturation or flag.
  - Reset to 0.
- Undefined: the port and the counter are absent. Pulse behaviour is identical in both builds.

Test Plan:
- Reset, defaults: hold i_rst_n low 3 cycles with i_toggle_aclk=0 -> o_pulse_bclk=0 throughout and for 3 cycles after release; o_event_cnt=0.
- Single event: after warm-up, flip i_toggle_aclk 0->1 mid-cycle before edge k -> o_pulse_bclk=1 only after edge k+2 (±1), 0 two edges after first seen high, exactly one pulse.
- Both edges: flips 0->1, then 1->0 eight cycles later -> exactly two one-cycle pulses; o_event_cnt=2 when the feature is enabled.
- Toggle high during reset: i_toggle_aclk=1 across reset release -> no pulse in the 10 following cycles.
- Reset mid-flight: flip the toggle, then assert i_rst_n one cycle later -> o_pulse_bclk stays 0, no pulse after release.
- Counter wrap and depth: with CNT_W=8, deliver 256 spaced events -> o_event_cnt returns to 0. Separately, with SYNC_STAGES=3, latency becomes k+3 (±1).
